// File: rtl/order_scheduler.sv
// order_scheduler
//   Front end of the shift-window matching engine. Round-robin arbitration
//   picks at most one order per clock from NUM_SRC sources. The order goes
//   into the engine buy or sell lane, and the other lane carries its idle
//   sentinel. When the engine reports a cross, the trade is logged. The
//   engine window is then flushed with sentinels for FLUSH_LEN cycles, so
//   the same cross is never counted twice.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   run               1 = accept orders, 0 = sentinels only
//   req_valid/side    per-source order valid and side (0 buy, 1 sell)
//   req_price         per-source price, source i on bits [8i+7:8i]
//   req_ready         per-source accept, one-hot or zero (combinational)
//   eng_buy_price     registered buy-lane drive (idle 0x00)
//   eng_sell_price    registered sell-lane drive (idle 0xFF)
//   eng_match_flag    engine cross indication
//   eng_trade_price   engine midpoint trade price
//   trade_pulse       one-cycle pulse per logged trade
//   last_trade_price  most recent logged trade price
//   trade_count       logged trades, saturating at 0xFFFF
//   drop_count        discarded sentinel-valued orders, saturating at 0xFF
//   busy              high while the window is being flushed
module order_scheduler #(
  parameter int NUM_SRC   = 2,
  parameter int FLUSH_LEN = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [NUM_SRC-1:0]   req_valid,
  input  logic [NUM_SRC-1:0]   req_side,
  input  logic [8*NUM_SRC-1:0] req_price,
  output logic [NUM_SRC-1:0]   req_ready,
  output logic [7:0]           eng_buy_price,
  output logic [7:0]           eng_sell_price,
  input  logic                 eng_match_flag,
  input  logic [7:0]           eng_trade_price,
  output logic                 trade_pulse,
  output logic [7:0]           last_trade_price,
  output logic [15:0]          trade_count,
  output logic [7:0]           drop_count,
  output logic                 busy
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam logic [7:0] BUY_IDLE  = 8'h00;
  localparam logic [7:0] SELL_IDLE = 8'hFF;

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_nxt;
  logic [CNT_W-1:0] flush_cnt, flush_cnt_nxt;

  logic             grant_any;
  logic [PTR_W-1:0] grant_idx;
  int               scan_idx;
  logic             sel_side;
  logic [7:0]       sel_price;
  logic             sel_sentinel;
  logic             match_take;

  logic [7:0]       buy_p0, sell_p0;
  logic             trade_vld_p0;
  logic [7:0]       last_p0;
  logic [15:0]      trade_cnt;
  logic [7:0]       drop_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // An order priced at its own lane's idle value would look like "no order"
  // to the engine, so it is accepted but never injected.
  function automatic logic is_sentinel(input logic side, input logic [7:0] price);
    return side ? (price == SELL_IDLE) : (price == BUY_IDLE);
  endfunction

  // Round-robin grant. The search is a pure function of state, the match flag
  // and req_valid. It never looks back at req_ready, so there is no
  // combinational loop through a source.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = rr_ptr;
    scan_idx  = 0;
    req_ready = '0;
    if (state == ISSUE && !eng_match_flag) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        scan_idx = (int'(rr_ptr) + k) % NUM_SRC;
        if (!grant_any && req_valid[scan_idx]) begin
          grant_any = 1'b1;
          grant_idx = PTR_W'(scan_idx);
        end
      end
      if (grant_any) req_ready[grant_idx] = 1'b1;
    end
  end

  assign sel_side     = req_side[grant_idx];
  assign sel_price    = req_price[{grant_idx, 3'b000} +: 8];
  assign sel_sentinel = is_sentinel(sel_side, sel_price);
  assign match_take   = (state == ISSUE) && eng_match_flag;
  assign rr_nxt       = grant_any ? PTR_W'((int'(grant_idx) + 1) % NUM_SRC) : rr_ptr;

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    busy          = 1'b0;
    unique case (state)
      IDLE: begin
        if (run) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (eng_match_flag) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = CNT_W'(FLUSH_LEN - 1);
        end else if (!run) begin
          state_nxt = IDLE;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        // run is only looked at on the last flush cycle, so dropping it
        // early never shortens the flush.
        if (flush_cnt == '0) state_nxt = run ? ISSUE : IDLE;
        else                 flush_cnt_nxt = flush_cnt - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // ---- stage p0: engine lane drive and trade log ----
  always_ff @(posedge clk) begin
    if (reset) begin
      buy_p0       <= BUY_IDLE;
      sell_p0      <= SELL_IDLE;
      trade_vld_p0 <= 1'b0;
      last_p0      <= 8'h00;
      trade_cnt    <= '0;
      drop_cnt     <= '0;
    end else begin
      buy_p0  <= BUY_IDLE;
      sell_p0 <= SELL_IDLE;
      if (grant_any && !sel_sentinel) begin
        if (sel_side) sell_p0 <= sel_price;
        else          buy_p0  <= sel_price;
      end
      if (grant_any && sel_sentinel) drop_cnt <= sat_inc8(drop_cnt);
      trade_vld_p0 <= match_take;
      if (match_take) begin
        last_p0   <= eng_trade_price;
        trade_cnt <= sat_inc16(trade_cnt);
      end
    end
  end

  assign eng_buy_price    = buy_p0;
  assign eng_sell_price   = sell_p0;
  assign trade_pulse      = trade_vld_p0;
  assign last_trade_price = last_p0;
  assign trade_count      = trade_cnt;
  assign drop_count       = drop_cnt;

endmodule

// File: tb/tb_order_scheduler.sv
// Testbench for order_scheduler (NUM_SRC = 2, FLUSH_LEN = 8).
// The stimulus pushes expected grants, lane injections and trades into
// queues. A negedge monitor pops and compares whenever the DUT shows one.
module tb_order_scheduler;

  localparam int NUM_SRC = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 run;
  logic [NUM_SRC-1:0]   req_valid;
  logic [NUM_SRC-1:0]   req_side;
  logic [8*NUM_SRC-1:0] req_price;
  logic [NUM_SRC-1:0]   req_ready;
  logic [7:0]           eng_buy_price;
  logic [7:0]           eng_sell_price;
  logic                 eng_match_flag;
  logic [7:0]           eng_trade_price;
  logic                 trade_pulse;
  logic [7:0]           last_trade_price;
  logic [15:0]          trade_count;
  logic [7:0]           drop_count;
  logic                 busy;

  order_scheduler #(.NUM_SRC(NUM_SRC), .FLUSH_LEN(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .run              (run),
    .req_valid        (req_valid),
    .req_side         (req_side),
    .req_price        (req_price),
    .req_ready        (req_ready),
    .eng_buy_price    (eng_buy_price),
    .eng_sell_price   (eng_sell_price),
    .eng_match_flag   (eng_match_flag),
    .eng_trade_price  (eng_trade_price),
    .trade_pulse      (trade_pulse),
    .last_trade_price (last_trade_price),
    .trade_count      (trade_count),
    .drop_count       (drop_count),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  logic mon_en = 1'b0;

  logic [NUM_SRC-1:0] grant_q[$];
  logic [15:0]        lane_q[$];   // {buy, sell}
  logic [23:0]        trade_q[$];  // {price, count}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  initial begin
    logic [NUM_SRC-1:0] eg;
    logic [15:0]        el;
    logic [23:0]        et;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (req_ready !== '0) begin
          if (grant_q.size() == 0) chk("grant_unexpected", 32'(req_ready), 32'd0);
          else begin
            eg = grant_q.pop_front();
            chk("grant", 32'(req_ready), 32'(eg));
          end
        end
        if (eng_buy_price !== 8'h00 || eng_sell_price !== 8'hFF) begin
          if (lane_q.size() == 0)
            chk("lane_unexpected", {16'd0, eng_buy_price, eng_sell_price}, 32'h000000FF);
          else begin
            el = lane_q.pop_front();
            chk("lane", {16'd0, eng_buy_price, eng_sell_price}, {16'd0, el});
          end
        end
        if (trade_pulse !== 1'b0) begin
          if (trade_q.size() == 0) chk("trade_unexpected", 32'(trade_pulse), 32'd0);
          else begin
            et = trade_q.pop_front();
            chk("trade", {8'd0, last_trade_price, trade_count}, {8'd0, et});
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; run = 1'b0; req_valid = '0; req_side = '0; req_price = '0;
    eng_match_flag = 1'b0; eng_trade_price = 8'h00;
    repeat (2) step();

    // Reset state
    @(negedge clk);
    chk("rst_buy",   32'(eng_buy_price),    32'h00);
    chk("rst_sell",  32'(eng_sell_price),   32'hFF);
    chk("rst_pulse", 32'(trade_pulse),      32'd0);
    chk("rst_last",  32'(last_trade_price), 32'h00);
    chk("rst_tcnt",  32'(trade_count),      32'd0);
    chk("rst_drop",  32'(drop_count),       32'd0);
    chk("rst_busy",  32'(busy),             32'd0);
    chk("rst_ready", 32'(req_ready),        32'd0);
    step();
    reset = 1'b0;
    mon_en = 1'b1;
    step();

    // Idle run: no requests for 20 cycles, lanes must stay at sentinels
    run = 1'b1;
    repeat (20) step();
    @(negedge clk);
    chk("idle_busy", 32'(busy),        32'd0);
    chk("idle_tcnt", 32'(trade_count), 32'd0);
    step();

    // Both sources buy 0x40 continuously: grants alternate 0,1,0,1,0,1
    for (int i = 0; i < 6; i++) begin
      grant_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
      lane_q.push_back(16'h40FF);
    end
    req_side = 2'b00; req_price = 16'h4040; req_valid = 2'b11;
    repeat (6) step();
    req_valid = 2'b00;

    // Cross: src0 buy 0x50, then src1 sell 0x48, engine reports 0x4C
    grant_q.push_back(2'b01); lane_q.push_back(16'h50FF);
    req_valid = 2'b01; req_side = 2'b00; req_price = 16'h0050;
    step();
    grant_q.push_back(2'b10); lane_q.push_back(16'h0048);
    req_valid = 2'b10; req_side = 2'b10; req_price = 16'h4800;
    step();
    // Match and a new request in the same cycle: match wins, request pends
    trade_q.push_back({8'h4C, 16'd1});
    req_valid = 2'b01; req_side = 2'b00; req_price = 16'h0030;
    eng_match_flag = 1'b1; eng_trade_price = 8'h4C;
    @(negedge clk);
    chk("match_no_grant", 32'(req_ready), 32'd0);
    step();
    eng_match_flag = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("flush_busy",  32'(busy),      32'd1);
      chk("flush_ready", 32'(req_ready), 32'd0);
      step();
    end
    grant_q.push_back(2'b01); lane_q.push_back(16'h30FF);
    @(negedge clk);
    chk("post_flush_busy", 32'(busy),        32'd0);
    chk("post_flush_tcnt", 32'(trade_count), 32'd1);
    step();
    req_valid = 2'b00;
    step();

    // Sentinel-valued orders: sell 0xFF then buy 0x00 from src0
    grant_q.push_back(2'b01);
    req_valid = 2'b01; req_side = 2'b01; req_price = 16'h00FF;
    step();
    grant_q.push_back(2'b01);
    req_side = 2'b00; req_price = 16'h0000;
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk("drop_count", 32'(drop_count),  32'd2);
    chk("drop_tcnt",  32'(trade_count), 32'd1);
    step();

    // Reset on the 3rd flush cycle
    trade_q.push_back({8'h77, 16'd2});
    eng_match_flag = 1'b1; eng_trade_price = 8'h77;
    step();
    eng_match_flag = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy),             32'd0);
    chk("mid_rst_tcnt", 32'(trade_count),      32'd0);
    chk("mid_rst_drop", 32'(drop_count),       32'd0);
    chk("mid_rst_last", 32'(last_trade_price), 32'h00);
    chk("mid_rst_lane", {16'd0, eng_buy_price, eng_sell_price}, 32'h000000FF);
    step();
    reset = 1'b0;
    grant_q.push_back(2'b01); lane_q.push_back(16'h22FF);
    grant_q.push_back(2'b10); lane_q.push_back(16'h23FF);
    req_valid = 2'b11; req_side = 2'b00; req_price = 16'h2322;
    step();  // IDLE -> ISSUE
    repeat (2) step();
    req_valid = 2'b00;
    step();

    // Saturation: preload 0xFFFE, two more matches
    force dut.trade_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.trade_cnt;
    step();
    trade_q.push_back({8'h99, 16'hFFFF});
    eng_match_flag = 1'b1; eng_trade_price = 8'h99;
    step();
    eng_match_flag = 1'b0;
    repeat (8) step();
    trade_q.push_back({8'hA5, 16'hFFFF});
    eng_match_flag = 1'b1; eng_trade_price = 8'hA5;
    step();
    eng_match_flag = 1'b0;
    repeat (8) step();
    @(negedge clk);
    chk("sat_tcnt", 32'(trade_count), 32'hFFFF);
    step();

    // run = 0: back to IDLE, no grants even with a pending request
    run = 1'b0;
    repeat (2) step();
    req_valid = 2'b01; req_side = 2'b00; req_price = 16'h0011;
    repeat (3) step();
    req_valid = 2'b00;
    repeat (4) step();

    chk("grant_q_left", 32'(grant_q.size()), 32'd0);
    chk("lane_q_left",  32'(lane_q.size()),  32'd0);
    chk("trade_q_left", 32'(trade_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/order_scheduler.md
Name: order_scheduler

Overview:
Front-end controller for the 8-deep shift-window matching engine. It arbitrates between NUM_SRC order sources with round-robin priority and injects at most one order per clock into the engine's buy or sell lane. The unused lane is driven with the idle sentinel (buy 0x00, sell 0xFF). When the engine reports a match, the block logs the trade and flushes the engine window with sentinels so each cross is counted exactly once. It sits between the order sources (switches/generator) and the matching engine; its trade outputs feed the VGA analytics path.

Parameters:
NUM_SRC, 2, number of order requesters (2..8)
FLUSH_LEN, 8, sentinel cycles injected after a match (must be >= engine window depth 8)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
run  in  1  1 = accept orders; 0 = inject sentinels only
req_valid  in  NUM_SRC  per-source order valid
req_side  in  NUM_SRC  per-source side, 0 = buy, 1 = sell
req_price  in  8*NUM_SRC  per-source price; source i uses bits [8i+7:8i]
req_ready  out  NUM_SRC  per-source accept, one-hot or zero, combinational
eng_buy_price  out  8  registered drive to engine buy input
eng_sell_price  out  8  registered drive to engine sell input
eng_match_flag  in  1  engine match indication
eng_trade_price  in  8  engine midpoint trade price
trade_pulse  out  1  one-cycle pulse per logged trade
last_trade_price  out  8  most recent logged trade price
trade_count  out  16  logged trades, saturating at 0xFFFF
drop_count  out  8  sentinel-valued orders discarded, saturating at 0xFF
busy  out  1  high while in FLUSH

Behaviour:
- Reset (sync, active-high, overrides everything incl. mid-FLUSH), values after reset:
  - state = IDLE, rr pointer = 0, flush counter = 0.
  - eng_buy_price = 0x00, eng_sell_price = 0xFF.
  - trade_pulse = 0, last_trade_price = 0x00, trade_count = 0, drop_count = 0, busy = 0.
- States: IDLE, ISSUE, FLUSH.
  - IDLE -> ISSUE when run = 1.
  - ISSUE -> IDLE when run = 0 and eng_match_flag = 0.
  - ISSUE -> FLUSH when eng_match_flag = 1 (takes priority over run = 0).
  - FLUSH -> ISSUE or IDLE (per run) after FLUSH_LEN cycles.
  - eng_match_flag is ignored in IDLE and FLUSH.
- Grant (combinational): only in ISSUE with eng_match_flag = 0.
  - Select the first source with req_valid = 1, searching from rr pointer upward with wrap.
  - req_ready is one-hot on the granted source, else all zero.
  - req_ready never depends on the selected source's own req_ready.
- Handshake: an order is consumed at a rising edge where req_valid[i] & req_ready[i].
  - The source holds valid/side/price stable until consumed.
  - On consumption, rr pointer becomes i+1 mod NUM_SRC; otherwise the pointer is unchanged.
- Engine drive, registered, one order per cycle:
  - Buy consumed at edge t: eng_buy_price = price and eng_sell_price = 0xFF from edge t.
  - Sell consumed: eng_sell_price = price and eng_buy_price = 0x00.
  - No consumption: both lanes = sentinels.
  - The engine latches the order on edge t+1.
- Sentinel orders (buy price 0x00 or sell price 0xFF) are still handshaked (ready asserted, consumed) but are not injected: sentinels are driven instead and drop_count increments.
- Match: on the ISSUE edge where eng_match_flag = 1:
  - Load last_trade_price = eng_trade_price.
  - trade_count += 1 (saturating).
  - trade_pulse = 1 for exactly the next cycle.
  - Enter FLUSH with counter = FLUSH_LEN-1.
- FLUSH:
  - busy = 1, req_ready = 0, both engine lanes at sentinels.
  - Counter decrements each cycle; on the cycle the counter equals 0, exit per run.
  - Total FLUSH dwell = FLUSH_LEN cycles.
- Simultaneous events: a match and a valid request in the same cycle -> the match wins, no grant, and the request stays pending.
- run dropping mid-FLUSH does not shorten the flush.
- Width rules: prices are unsigned 8-bit and pass through unmodified; no arithmetic on prices.

Test Plan:
- Reset, then run = 1, no requests, 20 cycles -> eng_buy_price = 0x00, eng_sell_price = 0xFF throughout; trade_count = 0; busy = 0.
- NUM_SRC = 2, both sources valid continuously with buy 0x40 -> grants alternate src0, src1, src0, ... one per cycle; eng_buy_price = 0x40 every cycle after the first edge.
- Src0 buy 0x50, then src1 sell 0x48 -> engine crosses; trade_pulse fires once; last_trade_price = 0x4C; trade_count = 1; busy high for exactly 8 cycles with req_ready = 0; no second count.
- Src0 sell 0xFF and buy 0x00 -> both consumed; drop_count = 2; engine lanes stay at sentinels; no trade.
- Assert reset on the 3rd FLUSH cycle -> next cycle: state IDLE, busy = 0, counts = 0, lanes at sentinels; with run = 1, grants resume from src0.
- Force trade_count to 0xFFFF via repeated crosses or a preload; one more match -> count stays 0xFFFF and trade_pulse still fires.
